// File: rtl/fifo_1r1w.sv
// First-word-fall-through FIFO over a synchronous-read RAM. A bypass register
// covers the RAM's read latency when a word lands in an empty FIFO.

module ram_1r1w_sync #(
  parameter  int DataWidth  = 8,
  parameter  int NumEntries = 16,
  localparam int AddrWidth  = $clog2(NumEntries)
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [DataWidth-1:0] mem [NumEntries];

  // Read returns the pre-write contents on an address collision.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

module fifo_1r1w #(
  parameter int DataWidth  = 8,
  parameter int NumEntries = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  input  logic                 ready_i
);

  localparam int PtrWidth = $clog2(NumEntries);
  localparam logic [PtrWidth:0] FullCount = NumEntries[PtrWidth:0];
  localparam logic [PtrWidth-1:0] PtrOne = {{(PtrWidth-1){1'b0}}, 1'b1};

  logic [PtrWidth:0]   count, count_next;
  logic [PtrWidth-1:0] wr_ptr, wr_ptr_next;
  logic [PtrWidth-1:0] rd_ptr, rd_ptr_next;
  logic                valid_next;
  logic                bypass_sel, bypass_sel_next;
  logic                bypass_load;
  logic [DataWidth-1:0] bypass_data;
  logic [DataWidth-1:0] ram_rd_data;
  logic                push, pop;

  assign ready_o = (count < FullCount) & ~reset_i;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // A word becomes the head straight away when nothing else will be in front
  // of it after this edge; the RAM cannot return it in time, so it is latched.
  assign bypass_load = push & ((count == '0) |
                               ((count == {{PtrWidth{1'b0}}, 1'b1}) & pop));

  always_comb begin
    count_next      = count;
    wr_ptr_next     = wr_ptr;
    rd_ptr_next     = rd_ptr;
    bypass_sel_next = bypass_sel;
    if (push) begin
      wr_ptr_next = wr_ptr + PtrOne;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr + PtrOne;
    end
    if (push & ~pop) begin
      count_next = count + 1'b1;
    end else if (pop & ~push) begin
      count_next = count - 1'b1;
    end
    if (bypass_load) begin
      bypass_sel_next = 1'b1;
    end else if (pop) begin
      bypass_sel_next = 1'b0;
    end
    valid_next = (count_next != '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      bypass_sel <= 1'b0;
      valid_o    <= 1'b0;
    end else begin
      count      <= count_next;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      bypass_sel <= bypass_sel_next;
      valid_o    <= valid_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (bypass_load) begin
      bypass_data <= data_i;
    end
  end

  // Look-ahead read: address the word that will be the head after this edge.
  ram_1r1w_sync #(
    .DataWidth (DataWidth),
    .NumEntries(NumEntries)
  ) u_ram (
    .clk_i    (clk_i),
    .wr_en_i  (push),
    .wr_addr_i(wr_ptr),
    .wr_data_i(data_i),
    .rd_addr_i(rd_ptr_next),
    .rd_data_o(ram_rd_data)
  );

  assign data_o = bypass_sel ? bypass_data : ram_rd_data;

endmodule
